uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial UART transmitter. It is the transmit end of the byte link whose receive end feeds the ICCM programming controller.
- Returns boot/programming status bytes (ACK/NAK, checksums) to the host over a dedicated pin.
- A small byte FIFO decouples the producer from line timing.
- Bit period is set at run time in clock cycles, matching the receiver's CLKS_PER_BIT convention (8N1, LSB first).

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of two, >=2
CPB_W, 16, width of bit-period input

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
clks_per_bit_i  in  CPB_W  clock cycles per bit; 0 is treated as 1
tx_valid_i  in  1  producer has a byte
tx_byte_i  in  8  byte to send
tx_ready_o  out  1  FIFO can accept (= !full)
tx_serial_o  out  1  serial line, idle high
tx_busy_o  out  1  frame in progress or FIFO non-empty
tx_done_o  out  1  one-cycle pulse at end of each stop bit
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: tx_serial_o=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0, fifo_level_o=0, FSM=IDLE.
- Asserting rst_i at any time, including mid-frame, clears the FIFO, aborts the frame and forces tx_serial_o=1 immediately.
- Handshake: a byte is accepted on a rising edge when tx_valid_i && tx_ready_o. tx_ready_o=0 when full; pushes while full are ignored.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: on the first edge with FIFO non-empty, pop the head into the shift register. Latch clks_per_bit_i as cpb_q (0 becomes 1), clear the bit counter, go to START.
  - The start bit appears on tx_serial_o after the second edge following acceptance into an empty FIFO.
- START: drive 0 for cpb_q cycles, then go to DATA.
- DATA: drive shift[0] for cpb_q cycles per bit, shift right, LSB first. After 8 bits go to STOP (or PARITY if enabled).
- STOP: drive 1 for cpb_q cycles. On the final cycle, pulse tx_done_o.
  - If the FIFO is non-empty on that edge, pop and go directly to START with no idle cycle.
  - Otherwise go to IDLE.
- tx_serial_o is registered (glitch-free).
- The cycle counter counts 0..cpb_q-1. The bit index is 3 bits and wraps only at the DATA exit.
- Changes to clks_per_bit_i mid-frame have no effect until the next frame start.
- On a simultaneous push and pop, the level is unchanged. fifo_level_o is exact, 0..FIFO_DEPTH.
- Frame length is 10*cpb_q cycles (11*cpb_q with parity).

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state follows DATA. It drives the even parity bit (XOR of the 8 data bits) for cpb_q cycles, then goes to STOP.
- Undefined: the PARITY state and its logic are absent; DATA goes straight to STOP.
- The port list is identical in both builds.

Decomposition:
- Package uart_tx_pkg holds:
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - UART_DATA_BITS=8
  - UART_DEFAULT_CPB=16'd10417
- Sub-module uart_tx_fifo: synchronous FIFO (push/pop, full/empty, level) with async active-high clear, parameterised by depth and width.
- The FSM, counters and shift register live in the top module.

Test Plan:
- Single byte: CPB=4, push 0xA5. Required line: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. tx_done_o pulses once, 40 cycles after the start bit begins; tx_busy_o then deasserts.
- Back-to-back: CPB=4, push 0x55 then 0x0F on consecutive cycles. The second start bit immediately follows the first stop bit with no gap; total 80 cycles; exactly 2 tx_done_o pulses.
- Backpressure: CPB=4, tx_valid_i held high with 5 distinct bytes. One is popped, so after the 5th acceptance fifo_level_o=4 and tx_ready_o=0. All 5 bytes are later transmitted in order with no loss or duplication.
- Reset mid-frame: assert rst_i during DATA bit 3. tx_serial_o=1 without waiting for a clock edge and fifo_level_o=0. After release, the line stays idle until the next push.
- Boundary: clks_per_bit_i=0 behaves as 1 (10-cycle frame). Changing CPB from 4 to 8 mid-frame leaves the current frame at 4 cycles per bit; the next frame uses 8.
- Loopback and parity: tx_serial_o → uart_receiver with CPB=16, bytes 0x00, 0xFF, 0x3C; the receiver reports identical bytes. With UART_TX_PARITY_EN, 0x07 produces a parity bit of 1 and an 11-bit frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// tx_state_e lists every state. PARITY is only reachable when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int          UART_DATA_BITS   = 8;
    localparam logic [15:0] UART_DEFAULT_CPB = 16'd10417;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO with asynchronous active-high clear.
// The head entry is read combinationally, so the consumer can load it on the same edge that pops it.
// A push while full is dropped. A pop while empty is ignored. A simultaneous push and pop keeps the level unchanged.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and level. The depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage write. The contents need no reset because the level gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// The bit period is latched from clks_per_bit_i at each frame start. A value of 0 is treated as 1.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.
// tx_serial_o comes from a register loaded from next-state values, so the line never glitches.
module uart_transmitter
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CPB_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [CPB_W-1:0]              clks_per_bit_i,
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_byte_i,
    output logic                          tx_ready_o,
    output logic                          tx_serial_o,
    output logic                          tx_busy_o,
    output logic                          tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam logic [CPB_W-1:0] CPB_ONE = CPB_W'(1);

    tx_state_e        state_q, state_d;
    logic [CPB_W-1:0] cnt_q, cnt_d;
    logic [CPB_W-1:0] cpb_q, cpb_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             serial_q, serial_d;
    logic             frame_load;
    logic             bit_end;
    logic             done_pulse;
    logic [CPB_W-1:0] cpb_eff;

    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_valid_i),
        .pop_i   (fifo_pop),
        .data_i  (tx_byte_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign cpb_eff      = (clks_per_bit_i == '0) ? CPB_ONE : clks_per_bit_i;
    assign bit_end      = (cnt_q == cpb_q - CPB_ONE);
    assign tx_ready_o   = !fifo_full;
    assign tx_busy_o    = (state_q != IDLE) || !fifo_empty;
    assign tx_done_o    = done_pulse;
    assign tx_serial_o  = serial_q;

    // Next-state logic for the frame sequencer, the cycle counter and the shift register.
    // The line value is derived from the next state, so it changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpb_d      = cpb_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        frame_load = 1'b0;
        done_pulse = 1'b0;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) frame_load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CPB_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CPB_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CPB_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_pulse = 1'b1;
                    cnt_d      = '0;
                    // A queued byte starts its frame at once, with no idle cycle between frames.
                    if (!fifo_empty) frame_load = 1'b1;
                    else             state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CPB_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_load) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            cpb_d     = cpb_eff;
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            par_d     = ^fifo_head;
`endif
        end

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = par_d;
`endif
            default: serial_d = 1'b1;
        endcase
    end

    // Sequencer registers. Reset aborts any frame and forces the line idle without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cpb_q     <= CPB_ONE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpb_q     <= cpb_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even-parity bit, computed once when the byte is loaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter.
// A negedge monitor logs the line, done and busy every cycle.
// Each test derives the expected frame from the byte and the bit period:
// start 0, eight data bits LSB first, an optional even-parity bit, then stop 1.
// It then compares that frame against the log, and also decodes the log with a mid-bit sampling receiver.
module tb_uart_transmitter;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB_W      = 16;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CPB_W-1:0] cpb = 16'd4;
    logic             valid = 1'b0;
    logic [7:0]       tx_byte = 8'h00;
    logic             tx_ready;
    logic             tx_serial;
    logic             tx_busy;
    logic             tx_done;
    logic [LW-1:0]    fifo_level;

    int n_checks = 0;
    int n_pass   = 0;

    logic line_log[$];
    logic done_log[$];
    logic busy_log[$];

    uart_transmitter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CPB_W      (CPB_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clks_per_bit_i (cpb),
        .tx_valid_i     (valid),
        .tx_byte_i      (tx_byte),
        .tx_ready_o     (tx_ready),
        .tx_serial_o    (tx_serial),
        .tx_busy_o      (tx_busy),
        .tx_done_o      (tx_done),
        .fifo_level_o   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        line_log.push_back(tx_serial);
        done_log.push_back(tx_done);
        busy_log.push_back(tx_busy);
    end

    // Advance to one time unit after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        valid   = 1'b1;
        tx_byte = b;
        tick();
        valid   = 1'b0;
    endtask

    function automatic int fl(input int c);
        return (10 + PAR) * ((c == 0) ? 1 : c);
    endfunction

    function automatic logic get_line(input int i);
        if (i < 0 || i >= line_log.size()) return 1'bx;
        return line_log[i];
    endfunction

    function automatic logic get_done(input int i);
        if (i < 0 || i >= done_log.size()) return 1'bx;
        return done_log[i];
    endfunction

    function automatic logic get_busy(input int i);
        if (i < 0 || i >= busy_log.size()) return 1'bx;
        return busy_log[i];
    endfunction

    function automatic int first_zero(input int from);
        for (int i = from; i < line_log.size(); i++)
            if (line_log[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int count_done(input int from);
        int n = 0;
        for (int i = from; i < done_log.size(); i++)
            if (done_log[i] === 1'b1) n++;
        return n;
    endfunction

    // Counts the logged line cycles that differ from the ideal frame for byte b at period c.
    function automatic int wave_errs(input int s, input logic [7:0] b, input int c);
        logic bits[$];
        int   errs = 0;
        int   ce   = (c == 0) ? 1 : c;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(b[k]);
        if (PAR != 0) bits.push_back(^b);
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++)
            for (int j = 0; j < ce; j++)
                if (get_line(s + k * ce + j) !== bits[k]) errs++;
        return errs;
    endfunction

    // Receiver model that samples each data bit at the middle of its period.
    function automatic logic [7:0] rx_byte(input int s, input int c);
        logic [7:0] r;
        int ce = (c == 0) ? 1 : c;
        for (int k = 0; k < 8; k++) r[k] = get_line(s + (k + 1) * ce + ce / 2);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        valid = 1'b0;
        cpb = 16'd4;
        tick(); tick(); tick();
        n_checks++; if (tx_serial !== 1'b1) $display("FAIL reset_serial got %b want 1", tx_serial); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else n_pass++;
        n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", tx_done); else n_pass++;
        n_checks++; if (fifo_level !== '0) $display("FAIL reset_level got %0d want 0", fifo_level); else n_pass++;
        rst = 1'b0;
        tick(); tick();
        n_checks++; if (tx_serial !== 1'b1 || tx_busy !== 1'b0) $display("FAIL post_reset_idle got serial %b busy %b want 1 0", tx_serial, tx_busy); else n_pass++;
    endtask

    task automatic test_single();
        int mark, s, e, nd;
        cpb  = 16'd4;
        mark = line_log.size();
        push(8'hA5);
        repeat (fl(4) + 6) tick();
        s = first_zero(mark);
        $display("single: byte a5 start index %0d", s - mark);
        n_checks++; if (s !== mark + 2) $display("FAIL single_latency got %0d want %0d", s - mark, 2); else n_pass++;
        e = wave_errs(s, 8'hA5, 4);
        n_checks++; if (e !== 0) $display("FAIL single_wave got %0d bad cycles want 0", e); else n_pass++;
        nd = count_done(mark);
        n_checks++; if (nd !== 1) $display("FAIL single_done_count got %0d want 1", nd); else n_pass++;
        n_checks++; if (get_done(s + fl(4) - 1) !== 1'b1) $display("FAIL single_done_pos got %b want 1", get_done(s + fl(4) - 1)); else n_pass++;
        n_checks++; if ({get_busy(s + fl(4) - 1), get_busy(s + fl(4))} !== 2'b10) $display("FAIL single_busy_drop got %b%b want 10", get_busy(s + fl(4) - 1), get_busy(s + fl(4))); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int mark, s, e0, e1, nd;
        cpb  = 16'd4;
        mark = line_log.size();
        valid = 1'b1; tx_byte = 8'h55; tick();
        tx_byte = 8'h0F; tick();
        valid = 1'b0;
        repeat (2 * fl(4) + 6) tick();
        s  = first_zero(mark);
        e0 = wave_errs(s, 8'h55, 4);
        e1 = wave_errs(s + fl(4), 8'h0F, 4);
        nd = count_done(mark);
        $display("back_to_back: bytes 55 0f done pulses %0d", nd);
        n_checks++; if (e0 !== 0) $display("FAIL b2b_wave0 got %0d bad cycles want 0", e0); else n_pass++;
        n_checks++; if (e1 !== 0) $display("FAIL b2b_wave1_nogap got %0d bad cycles want 0", e1); else n_pass++;
        n_checks++; if (nd !== 2) $display("FAIL b2b_done_count got %0d want 2", nd); else n_pass++;
        n_checks++; if ({get_done(s + fl(4) - 1), get_done(s + 2 * fl(4) - 1), get_busy(s + 2 * fl(4))} !== 3'b110)
            $display("FAIL b2b_done_busy got %b%b%b want 110", get_done(s + fl(4) - 1), get_done(s + 2 * fl(4) - 1), get_busy(s + 2 * fl(4))); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] b [5];
        int mark, s, g, nd;
        for (int i = 0; i < 5; i++) begin
            logic dup;
            do begin
                b[i] = 8'($urandom_range(0, 255));
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (b[j] == b[i]) dup = 1'b1;
            end while (dup);
        end
        cpb  = 16'd4;
        mark = line_log.size();
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_byte = b[i];
            g = 0;
            while (!tx_ready && g < 100) begin tick(); g++; end
            tick();
        end
        n_checks++; if (fifo_level !== LW'(4)) $display("FAIL bp_level_full got %0d want 4", fifo_level); else n_pass++;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", tx_ready); else n_pass++;
        tx_byte = 8'hEE;
        repeat (3) tick();
        n_checks++; if (fifo_level !== LW'(4)) $display("FAIL bp_push_while_full got level %0d want 4", fifo_level); else n_pass++;
        valid = 1'b0;
        repeat (5 * fl(4) + 10) tick();
        s = first_zero(mark);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] r;
            int e;
            r = rx_byte(s + i * fl(4), 4);
            e = wave_errs(s + i * fl(4), b[i], 4);
            $display("backpressure: frame %0d sent %02h received %02h", i, b[i], r);
            n_checks++; if (r !== b[i] || e !== 0) $display("FAIL bp_order frame %0d got %02h (%0d bad cycles) want %02h", i, r, e, b[i]); else n_pass++;
        end
        nd = count_done(mark);
        n_checks++; if (nd !== 5) $display("FAIL bp_done_count got %0d want 5", nd); else n_pass++;
        n_checks++; if (fifo_level !== '0 || tx_busy !== 1'b0) $display("FAIL bp_drain got level %0d busy %b want 0 0", fifo_level, tx_busy); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int mark, mark2, mark3, g, bad_line, bad_busy, s;
        logic [7:0] r;
        cpb  = 16'd4;
        mark = line_log.size();
        push(8'h00); push(8'h11); push(8'h22);
        // Data bit 3 of the first frame covers frame cycles 16..19, which are log entries mark+18..mark+21.
        g = 0;
        while (line_log.size() <= mark + 19 && g < 200) begin @(negedge clk); #1; g++; end
        n_checks++; if (tx_serial !== 1'b0 || fifo_level !== LW'(2)) $display("FAIL midframe_pre got serial %b level %0d want 0 2", tx_serial, fifo_level); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (tx_serial !== 1'b1) $display("FAIL midframe_async_serial got %b want 1", tx_serial); else n_pass++;
        n_checks++; if (fifo_level !== '0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) $display("FAIL midframe_async_clear got level %0d ready %b busy %b want 0 1 0", fifo_level, tx_ready, tx_busy); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        mark2 = line_log.size();
        repeat (30) tick();
        bad_line = 0; bad_busy = 0;
        for (int i = mark2; i < line_log.size(); i++) begin
            if (line_log[i] !== 1'b1) bad_line++;
            if (busy_log[i] !== 1'b0) bad_busy++;
        end
        n_checks++; if (bad_line !== 0 || bad_busy !== 0) $display("FAIL midframe_idle_after got %0d non-idle %0d busy cycles want 0 0", bad_line, bad_busy); else n_pass++;
        mark3 = line_log.size();
        push(8'h5A);
        repeat (fl(4) + 6) tick();
        s = first_zero(mark3);
        r = rx_byte(s, 4);
        $display("reset_midframe: recovery byte 5a received %02h", r);
        n_checks++; if (r !== 8'h5A || s !== mark3 + 2) $display("FAIL midframe_recover got %02h at %0d want 5a at 2", r, s - mark3); else n_pass++;
    endtask

    task automatic test_zero_cpb();
        int mark, s, e, nd;
        cpb  = 16'd0;
        mark = line_log.size();
        push(8'h96);
        repeat (fl(0) + 8) tick();
        s  = first_zero(mark);
        e  = wave_errs(s, 8'h96, 1);
        nd = count_done(mark);
        $display("zero_cpb: byte 96 frame cycles %0d", fl(0));
        n_checks++; if (e !== 0) $display("FAIL zero_cpb_wave got %0d bad cycles want 0", e); else n_pass++;
        n_checks++; if (get_done(s + fl(0) - 1) !== 1'b1 || nd !== 1) $display("FAIL zero_cpb_done got %b count %0d want 1 1", get_done(s + fl(0) - 1), nd); else n_pass++;
    endtask

    task automatic test_cpb_change();
        int mark, s, e0, e1, nd;
        cpb  = 16'd4;
        mark = line_log.size();
        valid = 1'b1; tx_byte = 8'hC3; tick();
        tx_byte = 8'h3A; tick();
        valid = 1'b0;
        repeat (8) tick();
        cpb = 16'd8;
        repeat (fl(4) + fl(8) + 10) tick();
        s  = first_zero(mark);
        e0 = wave_errs(s, 8'hC3, 4);
        e1 = wave_errs(s + fl(4), 8'h3A, 8);
        nd = count_done(mark);
        $display("cpb_change: frame0 c3 at 4, frame1 3a at 8, done pulses %0d", nd);
        n_checks++; if (e0 !== 0) $display("FAIL cpb_change_cur got %0d bad cycles want 0", e0); else n_pass++;
        n_checks++; if (e1 !== 0) $display("FAIL cpb_change_next got %0d bad cycles want 0", e1); else n_pass++;
        n_checks++; if (nd !== 2) $display("FAIL cpb_change_done got %0d want 2", nd); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] exp_b [3];
        int mark, s;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        cpb  = 16'd16;
        mark = line_log.size();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin tx_byte = exp_b[i]; tick(); end
        valid = 1'b0;
        repeat (3 * fl(16) + 10) tick();
        s = first_zero(mark);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] r;
            logic stop_bit;
            r = rx_byte(s + i * fl(16), 16);
            stop_bit = get_line(s + i * fl(16) + (9 + PAR) * 16 + 8);
            $display("loopback: sent %02h received %02h stop %b", exp_b[i], r, stop_bit);
            n_checks++; if (r !== exp_b[i] || stop_bit !== 1'b1) $display("FAIL loopback_byte%0d got %02h stop %b want %02h stop 1", i, r, stop_bit, exp_b[i]); else n_pass++;
        end
    endtask

    task automatic test_parity();
        int mark, s, e, nd;
        cpb  = 16'd4;
        mark = line_log.size();
        push(8'h07);
        repeat (fl(4) + 8) tick();
        s  = first_zero(mark);
        e  = wave_errs(s, 8'h07, 4);
        nd = count_done(mark);
        $display("parity: byte 07 expected frame %0d bit times", 10 + PAR);
        n_checks++; if (e !== 0) $display("FAIL parity_wave got %0d bad cycles want 0", e); else n_pass++;
        n_checks++; if (get_done(s + fl(4) - 1) !== 1'b1 || nd !== 1) $display("FAIL parity_frame_len got done %b count %0d want 1 1", get_done(s + fl(4) - 1), nd); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int mark, s, e, c;
            logic [7:0] b, r;
            c    = $urandom_range(1, 5);
            b    = 8'($urandom_range(0, 255));
            cpb  = CPB_W'(c);
            mark = line_log.size();
            push(b);
            repeat (fl(c) + 6) tick();
            s = first_zero(mark);
            e = wave_errs(s, b, c);
            r = rx_byte(s, c);
            $display("random: cpb %0d sent %02h received %02h", c, b, r);
            n_checks++; if (e !== 0 || r !== b) $display("FAIL random_frame%0d got %02h (%0d bad cycles) want %02h", it, r, e, b); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_zero_cpb();
        test_cpb_change();
        test_loopback();
        test_parity();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
